// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush controller.
// The datapath is the master: it drives the hazard and memory inputs and consumes the enables.
interface pipe_stall_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_MemRead;
    logic [4:0] ex_wn;
    logic       mem_req;
    logic       mem_ready;
    logic       branch_taken;
    logic       en_pc;
    logic       en_ifid;
    logic       en_idex;
    logic       en_exmem;
    logic       en_memwb;
    logic       flush_ifid;
    logic       flush_idex;
    logic [1:0] ctl_state;
    logic       mem_timeout_err;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_wn,
               mem_req, mem_ready, branch_taken,
        input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, ctl_state, mem_timeout_err
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_wn,
               mem_req, mem_ready, branch_taken,
        output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, ctl_state, mem_timeout_err
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, memory waits, branch flushes.
// Define STALL_PERF_CNT_EN to add the saturating stall_cycles performance counter output.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MWAIT   = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                en_front, en_back;
    logic                flush_ifid_c, flush_idex_c;
    logic                luh, mem_stall;

    assign luh = bus.ex_MemRead && (bus.ex_wn != 5'd0) &&
                 ((bus.ex_wn == bus.id_rs) || (bus.id_uses_rt && (bus.ex_wn == bus.id_rt)));
    assign mem_stall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        en_front     = 1'b1;
        en_back      = 1'b1;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    en_front = 1'b0;
                    en_back  = 1'b0;
                    state_d  = MWAIT;
                    cnt_d    = WCNT_W'(1);
                end else if (bus.branch_taken) begin
                    // The dependent instruction is flushed, so a concurrent load-use is moot.
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                end else if (luh) begin
                    en_front     = 1'b0;
                    flush_idex_c = 1'b1;
                    state_d      = LDSTALL;
                end
            end
            LDSTALL: begin
                if (mem_stall) begin
                    en_front = 1'b0;
                    en_back  = 1'b0;
                    state_d  = MWAIT;
                    cnt_d    = WCNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            MWAIT: begin
                if (bus.mem_ready) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    en_front = 1'b0;
                    en_back  = 1'b0;
                    if (cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WCNT_W'(1);
                    end
                end
            end
            default: begin
                en_front = 1'b0;
                en_back  = 1'b0;
                err_d    = 1'b1;
            end
        endcase
        // Reset must silence the pipeline immediately, not at the next edge.
        if (!rst) begin
            en_front     = 1'b0;
            en_back      = 1'b0;
            flush_ifid_c = 1'b0;
            flush_idex_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.en_pc           = en_front;
    assign bus.en_ifid         = en_front;
    assign bus.en_idex         = en_back;
    assign bus.en_exmem        = en_back;
    assign bus.en_memwb        = en_back;
    assign bus.flush_ifid      = flush_ifid_c && en_front;
    assign bus.flush_idex      = flush_idex_c && en_back;
    assign bus.ctl_state       = state_q;
    assign bus.mem_timeout_err = err_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!en_front && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif
endmodule
